// File: rtl/isqrt_share_arbiter.sv
// Shares one pipelined isqrt unit among N_REQ requesters: round-robin issue, owner-tag FIFO,
// in-order result return. Optional counters are enabled with ISQRT_SHARE_ARB_STATS_EN.
module isqrt_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ*32-1:0]    req_x,
  output logic [N_REQ-1:0]       req_rdy,
  output logic [N_REQ-1:0]       resp_vld,
  output logic [15:0]            resp_y,
  output logic                   isqrt_x_vld,
  output logic [31:0]            isqrt_x,
  input  logic                   isqrt_y_vld,
  input  logic [15:0]            isqrt_y,
  output logic                   err_underflow
`ifdef ISQRT_SHARE_ARB_STATS_EN
  ,
  output logic [31:0]            issue_cnt,
  output logic [$clog2(DEPTH):0] peak_inflight
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [IW-1:0] tag_t;

  tag_t          ptr;
  tag_t          grant_idx;
  tag_t          ptr_nxt;
  tag_t          head_tag;
  tag_t          tag_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [IW:0]   scan;
  logic [IW:0]   ptr_inc;
  logic [31:0]   grant_x;
  logic          full;
  logic          push;
  logic          pop;
  logic          underflow;

  // No full bypass: a pop in the same cycle does not open a slot for a new grant.
  assign full      = (count == CW'(DEPTH));
  assign pop       = isqrt_y_vld && (count != '0);
  assign underflow = isqrt_y_vld && (count == '0);
  assign head_tag  = tag_mem[rd_ptr];
  assign grant_x   = req_x[{grant_idx, 5'd0} +: 32];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req_rdy   = '0;
    grant_idx = '0;
    push      = 1'b0;
    scan      = '0;
    if (!full) begin
      for (int k = 0; k < N_REQ; k++) begin
        scan = {1'b0, ptr} + (IW+1)'(k);
        if (scan >= (IW+1)'(N_REQ)) scan = scan - (IW+1)'(N_REQ);
        if (!push && req_vld[scan[IW-1:0]]) begin
          push      = 1'b1;
          grant_idx = scan[IW-1:0];
        end
      end
      if (push) req_rdy[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_inc = {1'b0, grant_idx} + (IW+1)'(1);
    ptr_nxt = (ptr_inc == (IW+1)'(N_REQ)) ? '0 : ptr_inc[IW-1:0];
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      isqrt_x_vld   <= 1'b0;
      isqrt_x       <= '0;
      resp_vld      <= '0;
      resp_y        <= '0;
      err_underflow <= 1'b0;
    end else begin
      isqrt_x_vld <= push;
      if (push) begin
        isqrt_x <= grant_x;
        ptr     <= ptr_nxt;
        wr_ptr  <= wr_ptr + AW'(1);
      end
      resp_vld <= '0;
      if (pop) begin
        resp_vld <= N_REQ'(1) << head_tag;
        resp_y   <= isqrt_y;
        rd_ptr   <= rd_ptr + AW'(1);
      end
      if (underflow) err_underflow <= 1'b1;
      count <= count_nxt;
    end
  end

  // NOTE: tag storage has no reset; validity is carried entirely by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant_idx;
  end

`ifdef ISQRT_SHARE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt     <= '0;
      peak_inflight <= '0;
    end else begin
      if (push) issue_cnt <= issue_cnt + 32'd1;
      if (count_nxt > peak_inflight) peak_inflight <= count_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_isqrt_share_arbiter.sv
// Directed bench for isqrt_share_arbiter (N_REQ=4, DEPTH=4) with a behavioural isqrt pipeline
// whose latency and stall are controlled per scenario.
module tb_isqrt_share_arbiter;

  localparam int N = 4;
  localparam int D = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld;
  logic [N*32-1:0] req_x;
  logic [N-1:0]    req_rdy;
  logic [N-1:0]    resp_vld;
  logic [15:0]     resp_y;
  logic            isqrt_x_vld;
  logic [31:0]     isqrt_x;
  logic            isqrt_y_vld;
  logic [15:0]     isqrt_y;
  logic            err_underflow;

  isqrt_share_arbiter #(.N_REQ(N), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_vld      (req_vld),
    .req_x        (req_x),
    .req_rdy      (req_rdy),
    .resp_vld     (resp_vld),
    .resp_y       (resp_y),
    .isqrt_x_vld  (isqrt_x_vld),
    .isqrt_x      (isqrt_x),
    .isqrt_y_vld  (isqrt_y_vld),
    .isqrt_y      (isqrt_y),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] x; } job_t;
  typedef struct { logic [N-1:0] v; logic [15:0] y; } resp_t;

  int           n_pass = 0;
  int           n_total = 0;
  int           cyc = 0;
  int           lat = 3;
  bit           stall = 1'b0;
  int           release_n = 0;
  int           pend [N];
  logic [31:0]  xv [N];
  logic [N-1:0] gnt;
  logic [N-1:0] gnt_log [$];
  resp_t        resp_log [$];
  job_t         mq [$];

  function automatic logic [15:0] isqrt_ref(input logic [31:0] x);
    longint r = 0;
    while ((r + 1) * (r + 1) <= longint'(x)) r++;
    return 16'(r);
  endfunction

  task automatic set_req();
    for (int i = 0; i < N; i++) begin
      req_vld[i]        = (pend[i] != 0);
      req_x[32*i +: 32] = xv[i];
    end
  endtask

  // One clock: log the grant before the edge, then update requesters and the isqrt model after it.
  task automatic tick();
    @(negedge clk);
    gnt = req_vld & req_rdy;
    gnt_log.push_back(gnt);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (gnt[i] && pend[i] > 0) pend[i]--;
      req_vld[i] = (pend[i] != 0);
    end
    if (|resp_vld) resp_log.push_back('{resp_vld, resp_y});
    if (isqrt_x_vld) mq.push_back('{cyc + lat, isqrt_x});
    isqrt_y_vld = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc && (!stall || release_n > 0)) begin
      if (stall) release_n--;
      isqrt_y_vld = 1'b1;
      isqrt_y     = isqrt_ref(mq[0].x);
      void'(mq.pop_front());
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    set_req();
    isqrt_y_vld = 1'b0;
    mq.delete();
    stall     = 1'b0;
    release_n = 0;
    repeat (2) tick();
    rst = 1'b1;
    gnt_log.delete();
    resp_log.delete();
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    req_vld     = '0;
    req_x       = '0;
    isqrt_y_vld = 1'b0;
    isqrt_y     = '0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; xv[i] = '0; end
    #1 rst = 1'b0;
    #2;
    n_total++; if (req_rdy !== 4'b0000) $display("FAIL reset_req_rdy: got %b want 0000", req_rdy); else n_pass++;
    n_total++; if (resp_vld !== 4'b0000) $display("FAIL reset_resp_vld: got %b want 0000", resp_vld); else n_pass++;
    n_total++; if (resp_y !== 16'd0) $display("FAIL reset_resp_y: got %0d want 0", resp_y); else n_pass++;
    n_total++; if (isqrt_x_vld !== 1'b0) $display("FAIL reset_isqrt_x_vld: got %b want 0", isqrt_x_vld); else n_pass++;
    n_total++; if (isqrt_x !== 32'd0) $display("FAIL reset_isqrt_x: got %0d want 0", isqrt_x); else n_pass++;
    n_total++; if (err_underflow !== 1'b0) $display("FAIL reset_err_underflow: got %b want 0", err_underflow); else n_pass++;
    apply_reset();
  endtask

  task automatic test_contention();
    logic [N-1:0] e;
    logic [15:0]  ey [N];
    apply_reset();
    xv[0] = 32'd4; xv[1] = 32'd9; xv[2] = 32'd16; xv[3] = 32'd25;
    ey[0] = 16'd2; ey[1] = 16'd3; ey[2] = 16'd4;  ey[3] = 16'd5;
    for (int i = 0; i < N; i++) pend[i] = 1;
    set_req();
    #1;
    n_total++; if (req_rdy !== 4'b0001) $display("FAIL contention_first_rdy: got %b want 0001", req_rdy); else n_pass++;
    repeat (4) tick();
    repeat (6) tick();
    for (int i = 0; i < N; i++) begin
      e = 4'b0001 << i;
      n_total++;
      if (gnt_log[i] !== e) $display("FAIL contention_grant%0d: got %b want %b", i, gnt_log[i], e); else n_pass++;
    end
    n_total++;
    if (resp_log.size() != 4) $display("FAIL contention_resp_count: got %0d want 4", resp_log.size());
    else begin
      n_pass++;
      for (int i = 0; i < N; i++) begin
        e = 4'b0001 << i;
        n_total++;
        if (resp_log[i].v !== e || resp_log[i].y !== ey[i])
          $display("FAIL contention_resp%0d: got %b/%0d want %b/%0d", i, resp_log[i].v, resp_log[i].y, e, ey[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_single();
    lat = 3;
    pend[2] = 1; xv[2] = 32'd81;
    set_req();
    #1;
    n_total++; if (req_rdy !== 4'b0100) $display("FAIL single_rdy: got %b want 0100", req_rdy); else n_pass++;
    tick();
    n_total++; if (isqrt_x_vld !== 1'b1 || isqrt_x !== 32'd81)
      $display("FAIL single_issue: got %b/%0d want 1/81", isqrt_x_vld, isqrt_x); else n_pass++;
    tick();
    n_total++; if (isqrt_x_vld !== 1'b0 || isqrt_x !== 32'd81)
      $display("FAIL single_issue_idle: got %b/%0d want 0/81", isqrt_x_vld, isqrt_x); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_total++; if (resp_vld !== 4'b0000) $display("FAIL single_early_resp%0d: got %b want 0000", i, resp_vld); else n_pass++;
      tick();
    end
    n_total++; if (resp_vld !== 4'b0000) $display("FAIL single_early_resp2: got %b want 0000", resp_vld); else n_pass++;
    tick();
    n_total++; if (resp_vld !== 4'b0100 || resp_y !== 16'd9)
      $display("FAIL single_resp: got %b/%0d want 0100/9", resp_vld, resp_y); else n_pass++;
    tick();
    n_total++; if (resp_vld !== 4'b0000 || resp_y !== 16'd9)
      $display("FAIL single_resp_pulse: got %b/%0d want 0000/9", resp_vld, resp_y); else n_pass++;
  endtask

  task automatic test_fairness();
    logic [N-1:0] e;
    int n1;
    int n3;
    int ngr;
    apply_reset();
    lat = 1;
    pend[1] = 1000; xv[1] = 32'd49;
    pend[3] = 1000; xv[3] = 32'd100;
    set_req();
    repeat (10) tick();
    pend[1] = 0; pend[3] = 0;
    set_req();
    repeat (6) tick();
    for (int i = 0; i < 10; i++) begin
      e = (i % 2 == 0) ? 4'b0010 : 4'b1000;
      n_total++;
      if (gnt_log[i] !== e) $display("FAIL fair_grant%0d: got %b want %b", i, gnt_log[i], e); else n_pass++;
    end
    ngr = 0;
    foreach (gnt_log[i]) if (gnt_log[i] != 0) ngr++;
    n_total++; if (ngr != 10) $display("FAIL fair_total_grants: got %0d want 10", ngr); else n_pass++;
    n1 = 0; n3 = 0;
    foreach (resp_log[i]) begin
      if (resp_log[i].v === 4'b0010 && resp_log[i].y === 16'd7)  n1++;
      if (resp_log[i].v === 4'b1000 && resp_log[i].y === 16'd10) n3++;
    end
    n_total++; if (n1 != 5) $display("FAIL fair_resp_req1: got %0d want 5", n1); else n_pass++;
    n_total++; if (n3 != 5) $display("FAIL fair_resp_req3: got %0d want 5", n3); else n_pass++;
    n_total++; if (resp_log.size() != 10) $display("FAIL fair_resp_total: got %0d want 10", resp_log.size()); else n_pass++;
  endtask

  task automatic test_full();
    logic [N-1:0] e;
    logic [N-1:0] ev [6];
    logic [15:0]  ey [6];
    lat = 3;
    stall = 1'b1;
    gnt_log.delete();
    resp_log.delete();
    xv[0] = 32'd36; xv[1] = 32'd64; xv[2] = 32'd121; xv[3] = 32'd144;
    pend[0] = 2; pend[1] = 2; pend[2] = 1; pend[3] = 1;
    set_req();
    #1;
    n_total++; if (req_rdy !== 4'b0001) $display("FAIL full_first_rdy: got %b want 0001", req_rdy); else n_pass++;
    repeat (4) tick();
    for (int i = 0; i < N; i++) begin
      e = 4'b0001 << i;
      n_total++;
      if (gnt_log[i] !== e) $display("FAIL full_grant%0d: got %b want %b", i, gnt_log[i], e); else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      n_total++; if (req_rdy !== 4'b0000) $display("FAIL full_blocked%0d: got %b want 0000", i, req_rdy); else n_pass++;
      if (i < 3) tick();
    end
    release_n = 1;
    tick();
    n_total++; if (req_rdy !== 4'b0000) $display("FAIL full_pop_cycle_rdy: got %b want 0000", req_rdy); else n_pass++;
    tick();
    n_total++; if (req_rdy !== 4'b0001) $display("FAIL full_after_pop_rdy: got %b want 0001", req_rdy); else n_pass++;
    n_total++; if (resp_vld !== 4'b0001 || resp_y !== 16'd6)
      $display("FAIL full_first_resp: got %b/%0d want 0001/6", resp_vld, resp_y); else n_pass++;
    stall = 1'b0;
    repeat (16) tick();
    ev[0] = 4'b0001; ev[1] = 4'b0010; ev[2] = 4'b0100; ev[3] = 4'b1000; ev[4] = 4'b0001; ev[5] = 4'b0010;
    ey[0] = 16'd6;   ey[1] = 16'd8;   ey[2] = 16'd11;  ey[3] = 16'd12;  ey[4] = 16'd6;   ey[5] = 16'd8;
    n_total++;
    if (resp_log.size() != 6) $display("FAIL full_resp_count: got %0d want 6", resp_log.size());
    else begin
      n_pass++;
      for (int i = 0; i < 6; i++) begin
        n_total++;
        if (resp_log[i].v !== ev[i] || resp_log[i].y !== ey[i])
          $display("FAIL full_resp%0d: got %b/%0d want %b/%0d", i, resp_log[i].v, resp_log[i].y, ev[i], ey[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_underflow();
    isqrt_y     = 16'd77;
    isqrt_y_vld = 1'b1;
    tick();
    n_total++; if (err_underflow !== 1'b1) $display("FAIL uf_set: got %b want 1", err_underflow); else n_pass++;
    n_total++; if (resp_vld !== 4'b0000) $display("FAIL uf_no_resp: got %b want 0000", resp_vld); else n_pass++;
    n_total++; if (resp_y !== 16'd8) $display("FAIL uf_resp_y_hold: got %0d want 8", resp_y); else n_pass++;
    tick();
    n_total++; if (err_underflow !== 1'b1) $display("FAIL uf_sticky: got %b want 1", err_underflow); else n_pass++;
    pend[0] = 1; xv[0] = 32'd400;
    set_req();
    tick();
    n_total++; if (isqrt_x_vld !== 1'b1 || isqrt_x !== 32'd400)
      $display("FAIL uf_pre_reset_issue: got %b/%0d want 1/400", isqrt_x_vld, isqrt_x); else n_pass++;
    #1 rst = 1'b0;
    mq.delete();
    #1;
    n_total++; if (err_underflow !== 1'b0) $display("FAIL async_err: got %b want 0", err_underflow); else n_pass++;
    n_total++; if (isqrt_x_vld !== 1'b0 || isqrt_x !== 32'd0)
      $display("FAIL async_isqrt_x: got %b/%0d want 0/0", isqrt_x_vld, isqrt_x); else n_pass++;
    n_total++; if (resp_vld !== 4'b0000 || resp_y !== 16'd0)
      $display("FAIL async_resp: got %b/%0d want 0000/0", resp_vld, resp_y); else n_pass++;
    repeat (2) tick();
    rst = 1'b1;
    isqrt_y     = 16'd5;
    isqrt_y_vld = 1'b1;
    tick();
    n_total++; if (resp_vld !== 4'b0000) $display("FAIL flush_no_resp: got %b want 0000", resp_vld); else n_pass++;
    n_total++; if (err_underflow !== 1'b1) $display("FAIL flush_underflow: got %b want 1", err_underflow); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_fairness();
    test_full();
    test_underflow();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/isqrt_share_arbiter.md
Name: isqrt_share_arbiter

Overview:
- Shares one pipelined isqrt unit among N_REQ requesters, e.g. several formula FSMs that each need repeated square roots.
- Arbitrates issue slots round-robin and records the owner of each in-flight request in a tag FIFO.
- Routes each isqrt result back to its owner in issue order.
- Sits between the formula FSMs and the single isqrt instance; the isqrt unit itself is unchanged.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DEPTH, 16, max in-flight isqrt requests (power of 2, 2..64); tag FIFO depth

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_vld  in  N_REQ  per-requester request valid; held with req_x until accepted
- req_x  in  N_REQ*32  packed operands; requester i uses bits [32*i+31:32*i]
- req_rdy  out  N_REQ  one-hot grant; the request is accepted when req_vld[i] && req_rdy[i]
- resp_vld  out  N_REQ  one-hot result strobe to the owner
- resp_y  out  16  result value, shared by all requesters, valid with resp_vld
- isqrt_x_vld  out  1  to isqrt unit
- isqrt_x  out  32  to isqrt unit
- isqrt_y_vld  in  1  from isqrt unit; results arrive in issue order
- isqrt_y  in  16  from isqrt unit
- err_underflow  out  1  sticky; set when isqrt_y_vld arrives with the tag FIFO empty

Behaviour:
- Reset (rst low, asynchronous): all outputs 0; round-robin pointer points to requester 0 as next highest priority; FIFO count and read/write pointers 0; err_underflow cleared.
- req_rdy is combinational from req_vld, pointer and FIFO count:
  - If count == DEPTH, all bits are 0. A pop in the same cycle does not free the slot, so there is no full bypass.
  - Otherwise only the first i with req_vld[i]=1 gets req_rdy[i]=1, searching from ptr upward with wrap.
- On accept:
  - Next edge: isqrt_x_vld=1 and isqrt_x=operand, registered, so issue latency is 1 cycle.
  - Owner index is pushed into the tag FIFO.
  - ptr <= granted index + 1, mod N_REQ.
  - Back-to-back accepts every cycle are allowed.
- No accept: isqrt_x_vld=0 next cycle; isqrt_x holds its last value.
- ptr is unchanged when nothing is granted.
- On isqrt_y_vld with count > 0:
  - Pop the head tag.
  - Next edge: resp_vld = one-hot(tag), resp_y = isqrt_y, registered, so return latency is 1 cycle.
  - resp_vld is a single-cycle pulse. resp_y holds its value between pulses.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- On isqrt_y_vld with count == 0: no resp_vld; set err_underflow (stays set until reset); count stays 0.
- Requester rules:
  - A requester may hold req_vld while it has results outstanding.
  - Results for one requester return in its issue order.
  - A request is never dropped or duplicated.
- Reset mid-operation flushes all tags. Results still draining from the isqrt unit then count as underflow, so the isqrt unit must be reset together with this block.
- Width rules: FIFO entries are $clog2(N_REQ) bits; count is $clog2(DEPTH)+1 bits.

Optional Feature:
- Macro: ISQRT_SHARE_ARB_STATS_EN.
- When defined, the block adds:
  - Output issue_cnt, 32 bits: wrapping count of accepted requests.
  - Output peak_inflight, $clog2(DEPTH)+1 bits: maximum FIFO count seen since reset.
  - Both counters reset to 0.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single request, isqrt model with latency 3: req_vld[2]=1, x=81.
  - req_rdy[2]=1 in the same cycle.
  - Next cycle: isqrt_x_vld=1, isqrt_x=81.
  - isqrt_y=9 three cycles later, then resp_vld=4'b0100 and resp_y=9 one cycle after that.
- Contention: all four requesters hold req_vld with x = 4, 9, 16, 25 (requester 0..3) from reset.
  - Grants in cycles 0..3 go to requesters 0, 1, 2, 3.
  - resp_vld pulses 0001, 0010, 0100, 1000 with resp_y = 2, 3, 4, 5.
- Fairness: requesters 1 and 3 held valid continuously for 10 cycles.
  - Grants alternate 1, 3, 1, 3, ...
  - Each requester receives exactly 5 responses.
- Full FIFO: DEPTH=4, isqrt model stalled, 6 requests pending.
  - Exactly 4 accepts, then req_rdy stays 0.
  - Release one result: the cycle of that pop still shows no grant; a grant comes the next cycle.
- Underflow: isqrt_y_vld=1 with an empty FIFO.
  - err_underflow=1 and no resp_vld.
  - Asynchronous assertion of rst mid-stream clears err_underflow, the FIFO and all outputs immediately, without waiting for a clock edge.
